dat_write_sequencer: RTL and testbench

- Multi-block write controller that sits between the host-register/transfer logic and the single-block data-line writer.
- Issues one start per block to the writer and waits for the block buffer before each block.
- Inserts the mandatory inter-block gap, counts blocks, and stops on count exhaustion, an error, a stop-at-block-gap request or an abort.
- Aggregates completion and error status for the interrupt/status logic.

---
 rtl/dat_write_seq_pkg.sv | 18 +
 rtl/dat_write_sequencer_if.sv | 13 +
 rtl/dat_write_sequencer.sv | 176 +++++++++++++++++
 tb/tb_dat_write_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_write_seq_pkg.sv
// Purpose: shared state encoding and gap default for the multi-block write sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dat_write_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUF = 3'd1,
    ST_START    = 3'd2,
    ST_RUN      = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5
  } dat_wr_seq_state_e;

  // Minimum SD clock ticks between a writer done and the next writer start (Nwr).
  localparam int GapTicksDefault = 2;

endpackage

// File: rtl/dat_write_sequencer_if.sv
// Purpose: handshake bundle between the write sequencer and the single-block data-line writer.
// Latency: n/a (wires only).
// Backpressure: writer accepts dw_start on an SD tick; dw_done and error flags are sampled on SD ticks.
// Ports: dw_start (seq->writer), dw_done / dw_crc_err / dw_end_bit_err (writer->seq).
interface dat_write_sequencer_if;
  logic dw_start;
  logic dw_done;
  logic dw_crc_err;
  logic dw_end_bit_err;

  modport master (output dw_start, input dw_done, input dw_crc_err, input dw_end_bit_err);
  modport slave  (input dw_start, output dw_done, output dw_crc_err, output dw_end_bit_err);
endinterface

// File: rtl/dat_write_sequencer.sv
// Purpose: multi-block write controller: one writer start per block, inter-block gap, block count, status.
// Latency: start_i -> WAIT_BUF next cycle; dw_start held until an SD tick; xfer_done_o one cycle after final decision.
// Backpressure: stalls in WAIT_BUF until buf_block_ready_i; writer start is held until the SD tick.
// Ports: clk_i/rst_ni; host controls (start_i, multi_block_i, block_count_en_i, block_count_i,
//        stop_at_gap_i, abort_i, buf_block_ready_i); writer bundle dw; status outputs (busy_o,
//        block_done_o, xfer_done_o, crc_err_o, end_bit_err_o, stopped_at_gap_o, blocks_done_o).
module dat_write_sequencer
  import dat_write_seq_pkg::*;
#(
  parameter int BlockCountWidth = 16,
  parameter int GapTicks        = GapTicksDefault
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sd_clk_en_p_i,
  input  logic                       start_i,
  input  logic                       multi_block_i,
  input  logic                       block_count_en_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic                       stop_at_gap_i,
  input  logic                       abort_i,
  input  logic                       buf_block_ready_i,
  dat_write_sequencer_if.master      dw,
  output logic                       busy_o,
  output logic                       block_done_o,
  output logic                       xfer_done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       stopped_at_gap_o,
  output logic [BlockCountWidth-1:0] blocks_done_o
);

  localparam int GapW = (GapTicks > 0) ? $clog2(GapTicks + 1) : 1;
  localparam logic [GapW-1:0]            GapLast = GapW'(GapTicks);
  localparam logic [BlockCountWidth-1:0] CntOne  = BlockCountWidth'(1);

  dat_wr_seq_state_e            state_q, state_d;
  logic [BlockCountWidth-1:0]   remaining_q, remaining_d;
  logic [BlockCountWidth-1:0]   blocks_done_q, blocks_done_d;
  logic [GapW-1:0]              gap_cnt_q, gap_cnt_d;
  logic                         infinite_q, infinite_d;
  logic                         crc_err_q, crc_err_d;
  logic                         end_bit_err_q, end_bit_err_d;
  logic                         stopped_q, stopped_d;
  logic                         abort_pend_q, abort_pend_d;
  logic                         dw_start_s;
  logic                         blk_done_evt;

  // Writer status only counts on an SD tick.
  assign blk_done_evt = dw.dw_done & sd_clk_en_p_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      blocks_done_q <= '0;
      gap_cnt_q     <= '0;
      infinite_q    <= 1'b0;
      crc_err_q     <= 1'b0;
      end_bit_err_q <= 1'b0;
      stopped_q     <= 1'b0;
      abort_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      blocks_done_q <= blocks_done_d;
      gap_cnt_q     <= gap_cnt_d;
      infinite_q    <= infinite_d;
      crc_err_q     <= crc_err_d;
      end_bit_err_q <= end_bit_err_d;
      stopped_q     <= stopped_d;
      abort_pend_q  <= abort_pend_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    blocks_done_d = blocks_done_q;
    gap_cnt_d     = gap_cnt_q;
    infinite_d    = infinite_q;
    crc_err_d     = crc_err_q;
    end_bit_err_d = end_bit_err_q;
    stopped_d     = stopped_q;
    abort_pend_d  = abort_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort_i is deliberately not looked at here: a coincident start wins.
        if (start_i) begin
          remaining_d   = multi_block_i ? block_count_i : CntOne;
          infinite_d    = multi_block_i & ~block_count_en_i;
          blocks_done_d = '0;
          crc_err_d     = 1'b0;
          end_bit_err_d = 1'b0;
          stopped_d     = 1'b0;
          abort_pend_d  = 1'b0;
          state_d       = (!infinite_d && remaining_d == '0) ? ST_DONE : ST_WAIT_BUF;
        end
      end
      ST_WAIT_BUF: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          stopped_d = 1'b1;
        end else if (buf_block_ready_i) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Abort beats a coincident tick; the writer may have seen start, the host resets the line.
        if (abort_i) begin
          state_d   = ST_DONE;
          stopped_d = 1'b1;
        end else if (sd_clk_en_p_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A block in flight always completes; abort is only remembered.
        if (abort_i) abort_pend_d = 1'b1;
        if (blk_done_evt) begin
          blocks_done_d = blocks_done_q + CntOne;
          if (!infinite_q && remaining_q != '0) remaining_d = remaining_q - CntOne;
          crc_err_d     = crc_err_q | dw.dw_crc_err;
          end_bit_err_d = end_bit_err_q | dw.dw_end_bit_err;
          gap_cnt_d     = '0;
          state_d       = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          stopped_d = 1'b1;
        end else if (gap_cnt_q >= GapLast) begin
          if (crc_err_q || end_bit_err_q) begin
            state_d = ST_DONE;
          end else if (abort_pend_q || stop_at_gap_i) begin
            state_d   = ST_DONE;
            stopped_d = 1'b1;
          end else if (!infinite_q && remaining_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_BUF;
          end
        end else if (sd_clk_en_p_i) begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dw_start_s   = 1'b0;
    block_done_o = 1'b0;
    xfer_done_o  = 1'b0;
    unique case (state_q)
      ST_START: dw_start_s   = ~abort_i;
      ST_RUN:   block_done_o = blk_done_evt;
      ST_DONE:  xfer_done_o  = 1'b1;
      default:  ;
    endcase
  end

  assign dw.dw_start        = dw_start_s;
  assign busy_o             = (state_q != ST_IDLE);
  assign crc_err_o          = crc_err_q;
  assign end_bit_err_o      = end_bit_err_q;
  assign stopped_at_gap_o   = stopped_q;
  assign blocks_done_o      = blocks_done_q;

endmodule

// File: tb/tb_dat_write_sequencer.sv
module tb_dat_write_sequencer;
  localparam int BCW = 16;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sd_en = 1'b0, start = 1'b0, multi = 1'b0, cen = 1'b0;
  logic stop = 1'b0, abort = 1'b0, buf_rdy = 1'b0;
  logic [BCW-1:0] bcount = '0;
  logic busy, bdone, xdone, crc, eb, stopped;
  logic [BCW-1:0] bdone_cnt;

  dat_write_sequencer_if dwif();

  dat_write_sequencer #(.BlockCountWidth(BCW), .GapTicks(GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sd_clk_en_p_i(sd_en), .start_i(start),
    .multi_block_i(multi), .block_count_en_i(cen), .block_count_i(bcount),
    .stop_at_gap_i(stop), .abort_i(abort), .buf_block_ready_i(buf_rdy),
    .dw(dwif), .busy_o(busy), .block_done_o(bdone), .xfer_done_o(xdone),
    .crc_err_o(crc), .end_bit_err_o(eb), .stopped_at_gap_o(stopped),
    .blocks_done_o(bdone_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // SD tick generator: one tick every tick_div system cycles.
  int tick_div = 1;
  initial begin : tickgen
    int tc;
    tc = 0;
    forever begin
      @(posedge clk); #1;
      tc++;
      if (tc >= tick_div) begin sd_en = 1'b1; tc = 0; end
      else sd_en = 1'b0;
    end
  end

  // Event monitor, sampled on the falling edge.
  int n_acc = 0, n_scyc = 0, n_bd = 0, n_xd = 0, gap_viol = 0, tsd = 1000;
  always @(negedge clk) begin
    if (dwif.dw_start) n_scyc <= n_scyc + 1;
    if (dwif.dw_start && sd_en) begin
      n_acc <= n_acc + 1;
      if (tsd < GAP) gap_viol <= gap_viol + 1;
    end
    if (bdone) n_bd <= n_bd + 1;
    if (xdone) begin n_xd <= n_xd + 1; tsd <= 1000; end
    else if (bdone) tsd <= 0;
    else if (sd_en && tsd < 1000) tsd <= tsd + 1;
  end

  // Writer model: after an accepted start, wait wr_lat ticks then report done.
  int bfm_acc = 0, bfm_base = 0, wr_lat = 1, err_blk_cfg = 0;
  bit err_crc_cfg = 1'b0;
  initial begin : writer
    int n, blk;
    dwif.dw_done = 1'b0; dwif.dw_crc_err = 1'b0; dwif.dw_end_bit_err = 1'b0;
    forever begin
      @(negedge clk);
      if (dwif.dw_start && sd_en) begin
        bfm_acc++;
        blk = bfm_acc - bfm_base;
        n = 0;
        while (n < wr_lat) begin @(negedge clk); if (sd_en) n++; end
        @(posedge clk); #1;
        dwif.dw_done = 1'b1;
        dwif.dw_crc_err = (blk == err_blk_cfg) && err_crc_cfg;
        dwif.dw_end_bit_err = (blk == err_blk_cfg) && !err_crc_cfg;
        do @(negedge clk); while (!sd_en);
        @(posedge clk); #1;
        dwif.dw_done = 1'b0; dwif.dw_crc_err = 1'b0; dwif.dw_end_bit_err = 1'b0;
      end
    end
  end

  // Reference model: walk the transfer block by block.
  function automatic void model(input bit m, input bit ce, input int cnt, input int eblk,
                                input int sblk, output int nb, output bit err, output bit stp);
    bit inf;
    int limit;
    inf = m && !ce;
    limit = m ? cnt : 1;
    nb = 0; err = 1'b0; stp = 1'b0;
    for (int b = 1; b <= 100; b++) begin
      if (!inf && nb >= limit) break;
      nb = b;
      if (b == eblk) begin err = 1'b1; break; end
      if (b == sblk) begin stp = 1'b1; break; end
      if (!inf && nb == limit) break;
    end
  endfunction

  // Observations of the last transfer.
  int o_nb, o_acc, o_scyc, o_bd, o_xd, o_gv;
  bit o_crc, o_eb, o_stop, o_to;

  task automatic run_xfer(input bit m, input bit ce, input int cnt, input int eblk, input bit ecrc,
                          input int sblk, input int ablk, input int tdiv, input int lat, input bit noise);
    int a0, s0, b0, x0, g0, cyc;
    bit aborted;
    tick_div = tdiv; wr_lat = lat; err_blk_cfg = eblk; err_crc_cfg = ecrc; bfm_base = bfm_acc;
    a0 = n_acc; s0 = n_scyc; b0 = n_bd; x0 = n_xd; g0 = gap_viol;
    multi = m; cen = ce; bcount = cnt[BCW-1:0]; buf_rdy = 1'b1;
    start = 1'b1; abort = noise;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    cyc = 0; aborted = 1'b0;
    while (n_xd == x0 && cyc < 20000) begin
      start = noise && (cyc == 3);
      stop = (sblk > 0) && (n_acc - a0 >= sblk);
      abort = 1'b0;
      if (ablk > 0 && !aborted && (n_acc - a0 >= ablk)) begin abort = 1'b1; aborted = 1'b1; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; stop = 1'b0; abort = 1'b0;
    o_to = (cyc >= 20000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    o_nb = int'(bdone_cnt); o_crc = crc; o_eb = eb; o_stop = stopped;
    o_acc = n_acc - a0; o_scyc = n_scyc - s0; o_bd = n_bd - b0; o_xd = n_xd - x0; o_gv = gap_viol - g0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if ({busy, bdone, xdone, crc, eb, stopped, dwif.dw_start} !== 7'b0) begin bad++;
      $display("FAIL reset.flags got=%b want=0", {busy, bdone, xdone, crc, eb, stopped, dwif.dw_start}); end
    total++; if (bdone_cnt !== '0) begin bad++; $display("FAIL reset.blocks got=%0d want=0", bdone_cnt); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset.idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_block();
    run_xfer(1'b0, 1'b1, $urandom_range(0, 65535), 0, 1'b0, 0, 0, 2, 100, 1'b0);
    total++; if ({o_to, o_acc, o_bd, o_xd, o_nb} !== {1'b0, 32'd1, 32'd1, 32'd1, 32'd1}) begin bad++;
      $display("FAIL single.counts to=%0d starts=%0d bdone=%0d xdone=%0d blocks=%0d want 0/1/1/1/1", o_to, o_acc, o_bd, o_xd, o_nb); end
    total++; if ({o_crc, o_eb, o_stop} !== 3'b000) begin bad++;
      $display("FAIL single.flags got=%b want=000", {o_crc, o_eb, o_stop}); end
  endtask

  task automatic test_multi_block();
    run_xfer(1'b1, 1'b1, 3, 0, 1'b0, 0, 0, 4, 3, 1'b0);
    total++; if ({o_to, o_acc, o_nb, o_xd} !== {1'b0, 32'd3, 32'd3, 32'd1}) begin bad++;
      $display("FAIL multi.counts to=%0d starts=%0d blocks=%0d xdone=%0d want 0/3/3/1", o_to, o_acc, o_nb, o_xd); end
    total++; if (o_gv !== 0) begin bad++; $display("FAIL multi.gap short_gaps=%0d want=0", o_gv); end
  endtask

  task automatic test_crc_error();
    run_xfer(1'b1, 1'b1, 5, 2, 1'b1, 0, 0, 1, 2, 1'b0);
    total++; if ({o_acc, o_nb} !== {32'd2, 32'd2}) begin bad++;
      $display("FAIL crc.counts starts=%0d blocks=%0d want 2/2", o_acc, o_nb); end
    total++; if ({o_crc, o_eb, o_stop} !== 3'b100) begin bad++;
      $display("FAIL crc.flags got=%b want=100", {o_crc, o_eb, o_stop}); end
  endtask

  task automatic test_infinite_stop();
    run_xfer(1'b1, 1'b0, 2, 0, 1'b0, 4, 0, 2, 2, 1'b0);
    total++; if ({o_to, o_acc, o_nb, o_stop} !== {1'b0, 32'd4, 32'd4, 1'b1}) begin bad++;
      $display("FAIL inf_stop to=%0d starts=%0d blocks=%0d stopped=%0d want 0/4/4/1", o_to, o_acc, o_nb, o_stop); end
  endtask

  task automatic test_abort_wait_buf();
    int s0;
    s0 = n_scyc;
    multi = 1'b1; cen = 1'b1; bcount = 16'd3; buf_rdy = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    total++; if (xdone !== 1'b1) begin bad++; $display("FAIL abort_wb.xdone got=%b want=1", xdone); end
    @(posedge clk); @(negedge clk);
    total++; if ({busy, stopped, bdone_cnt} !== {1'b0, 1'b1, 16'd0}) begin bad++;
      $display("FAIL abort_wb.state busy=%b stopped=%b blocks=%0d want 0/1/0", busy, stopped, bdone_cnt); end
    total++; if (n_scyc - s0 !== 0) begin bad++; $display("FAIL abort_wb.start cycles=%0d want=0", n_scyc - s0); end
    buf_rdy = 1'b1;
  endtask

  task automatic test_abort_run();
    run_xfer(1'b1, 1'b1, 4, 0, 1'b0, 0, 2, 1, 3, 1'b0);
    total++; if ({o_to, o_acc, o_nb, o_bd, o_stop, o_xd} !== {1'b0, 32'd2, 32'd2, 32'd2, 1'b1, 32'd1}) begin bad++;
      $display("FAIL abort_run to=%0d starts=%0d blocks=%0d bdone=%0d stopped=%0d xdone=%0d want 0/2/2/2/1/1",
               o_to, o_acc, o_nb, o_bd, o_stop, o_xd); end
  endtask

  task automatic test_zero_count();
    run_xfer(1'b1, 1'b1, 0, 0, 1'b0, 0, 0, 1, 1, 1'b0);
    total++; if ({o_to, o_scyc, o_nb, o_xd, o_stop} !== {1'b0, 32'd0, 32'd0, 32'd1, 1'b0}) begin bad++;
      $display("FAIL zero_cnt to=%0d start_cycles=%0d blocks=%0d xdone=%0d stopped=%0d want 0/0/0/1/0",
               o_to, o_scyc, o_nb, o_xd, o_stop); end
  endtask

  task automatic test_start_abort_idle();
    run_xfer(1'b1, 1'b1, 2, 0, 1'b0, 0, 0, 1, 2, 1'b1);
    total++; if ({o_to, o_nb, o_xd, o_stop} !== {1'b0, 32'd2, 32'd1, 1'b0}) begin bad++;
      $display("FAIL start_abort to=%0d blocks=%0d xdone=%0d stopped=%0d want 0/2/1/0", o_to, o_nb, o_xd, o_stop); end
  endtask

  task automatic test_random();
    bit m, ce, ecrc, noise, e_err, e_stp;
    int cnt, eblk, mode, kblk, e_nb;
    for (int it = 0; it < 12; it++) begin
      m = 1'($urandom_range(0, 1)); ce = 1'($urandom_range(0, 1)); cnt = $urandom_range(0, 5);
      eblk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      ecrc = 1'($urandom_range(0, 1)); noise = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2); kblk = $urandom_range(1, 5);
      if (m && !ce && mode == 0) mode = 1;
      model(m, ce, cnt, eblk, (mode != 0) ? kblk : 0, e_nb, e_err, e_stp);
      run_xfer(m, ce, cnt, eblk, ecrc, (mode == 1) ? kblk : 0, (mode == 2) ? kblk : 0,
               $urandom_range(1, 4), $urandom_range(1, 6), noise);
      total++; if (o_nb !== e_nb) begin bad++;
        $display("FAIL rand%0d.blocks got=%0d want=%0d", it, o_nb, e_nb); end
      total++; if ({o_crc, o_eb, o_stop} !== {e_err && ecrc, e_err && !ecrc, e_stp}) begin bad++;
        $display("FAIL rand%0d.flags got=%b want=%b", it, {o_crc, o_eb, o_stop}, {e_err && ecrc, e_err && !ecrc, e_stp}); end
      total++; if ({o_to, o_acc, o_bd, o_xd, o_gv} !== {1'b0, e_nb, e_nb, 32'd1, 32'd0}) begin bad++;
        $display("FAIL rand%0d.events to=%0d starts=%0d bdone=%0d xdone=%0d short_gaps=%0d want 0/%0d/%0d/1/0",
                 it, o_to, o_acc, o_bd, o_xd, o_gv, e_nb, e_nb); end
    end
  endtask

  task automatic test_reset_in_run();
    int a0, b0, cyc;
    tick_div = 1; wr_lat = 30; err_blk_cfg = 0; bfm_base = bfm_acc;
    a0 = n_acc;
    multi = 1'b0; buf_rdy = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (n_acc == a0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc >= 100) begin bad++; $display("FAIL rst_run.reach_run timeout got=%0d want<100", cyc); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, bdone, xdone, crc, eb, stopped, dwif.dw_start, bdone_cnt} !== 23'b0) begin bad++;
      $display("FAIL rst_run.outputs got=%b want=0", {busy, bdone, xdone, crc, eb, stopped, dwif.dw_start, bdone_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    b0 = n_bd;
    repeat (60) @(posedge clk);
    @(negedge clk);
    total++; if ({busy, bdone_cnt, 32'(n_bd - b0)} !== 49'b0) begin bad++;
      $display("FAIL rst_run.late_done busy=%b blocks=%0d bdone=%0d want 0/0/0", busy, bdone_cnt, n_bd - b0); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_crc_error();
    test_infinite_stop();
    test_abort_wait_buf();
    test_abort_run();
    test_zero_count();
    test_start_abort_idle();
    test_random();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
